jamma_db9_scanner: RTL and testbench



---
 rtl/jamma_db9_pkg.sv | 24 ++
 rtl/jamma_tick_gen.sv | 39 +++
 rtl/jamma_db9_scanner.sv | 224 ++++++++++++++++++++++
 tb/tb_jamma_db9_scanner.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jamma_db9_pkg.sv
// Shared definitions for the JAMMA/DB9 joystick chain scanner.
//   scan_state_e  : scanner FSM states (IDLE, LOAD, SETTLE, SHIFT, DONE)
//   cnt_width()   : counter width for a modulus n, never less than 1 bit
//   frame_cycles(): clk_sys cycles from entering LOAD to the joy_out update
package jamma_db9_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SHIFT  = 3'd3,
    DONE   = 3'd4
  } scan_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int frame_cycles(input int num_ch, input int ch_bits,
                                      input int clk_div, input int load_ticks);
    return (load_ticks + 1 + 2 * num_ch * ch_bits) * clk_div + 1;
  endfunction

endpackage

// File: rtl/jamma_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV cycles of clk.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  restart the count from zero (takes priority over run)
//   run    in  count enable; the counter holds while low
//   tick   out high on the cycle the counter wraps from DIV-1 to 0
module jamma_tick_gen
  import jamma_db9_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int W = cnt_width(DIV);

  logic [W-1:0] cnt_q;
  logic         wrap;

  assign wrap = (cnt_q == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= wrap ? '0 : cnt_q + W'(1);
    end
  end

  assign tick = run && !clear && wrap;

endmodule

// File: rtl/jamma_db9_scanner.sv
// Active reader for the JAMMA/DB9 74HC165-style joystick chain.
// Drives the chain's load and shift clock, samples the serial data through
// a two-flop synchroniser and presents an active-high button word.
//
// Ports:
//   clk_sys     in   system clock
//   rst_n       in   asynchronous active-low reset
//   enable      in   allow new frames to start (a running frame always completes)
//   joy_data    in   serial chain data, buttons active-low
//   joy_clk     out  shift clock to the chain
//   joy_load_n  out  parallel-load strobe, active-low
//   joy_select  out  chain select, tied high
//   joy_out     out  captured buttons, active-high; channel k at [k*CH_BITS +: CH_BITS]
//   joy_valid   out  one-cycle pulse in the cycle joy_out takes a new value
//   busy        out  high while a frame is in progress
//
// Build option: define JAMMA_DB9_DEBOUNCE_EN to add a per-bit filter that only
// lets a button bit change when two consecutive frames agree on it.
//
// Output handshake: joy_valid has no ready; it is a single-cycle strobe that
// is high exactly in the first cycle a new joy_out value is visible. joy_out
// holds between strobes.
module jamma_db9_scanner
  import jamma_db9_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CH_BITS    = 12,
  parameter int CLK_DIV    = 8,
  parameter int LOAD_TICKS = 2,
  parameter int SCAN_GAP   = 1024
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      joy_data,
  output logic                      joy_clk,
  output logic                      joy_load_n,
  output logic                      joy_select,
  output logic [NUM_CH*CH_BITS-1:0] joy_out,
  output logic                      joy_valid,
  output logic                      busy
);

  localparam int TOTAL = NUM_CH * CH_BITS;
  localparam int GAP_W = cnt_width(SCAN_GAP);
  localparam int IDX_W = cnt_width(TOTAL);
  localparam int LT_W  = cnt_width(LOAD_TICKS);

  // Two-flop synchroniser on the chain data. Resets to the idle (released)
  // line level so nothing looks pressed before the first frame.
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= joy_data;
      sync2_q <= sync1_q;
    end
  end

  // Shift tick generator: idle in IDLE, restarted on entry to LOAD so the
  // load pulse always lasts a whole number of ticks.
  scan_state_e state_q, state_d;
  logic        tick;
  logic        prescale_clear;

  jamma_tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .clear (prescale_clear),
    .run   (state_q != IDLE),
    .tick  (tick)
  );

  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LT_W-1:0]  load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             phase_b_q, phase_b_d;
  logic [TOTAL-1:0] sr_q, sr_d;
  logic             joy_clk_q, joy_clk_d;
  logic [TOTAL-1:0] joy_out_q, joy_out_d;
  logic             valid_q, valid_d;

`ifdef JAMMA_DB9_DEBOUNCE_EN
  logic [TOTAL-1:0] prev_q, prev_d;
  logic [TOTAL-1:0] agree;
  assign agree = ~(sr_q ^ prev_q);
`endif

  always_comb begin
    state_d        = state_q;
    gap_d          = gap_q;
    load_cnt_d     = load_cnt_q;
    bit_idx_d      = bit_idx_q;
    phase_b_d      = phase_b_q;
    sr_d           = sr_q;
    joy_clk_d      = joy_clk_q;
    joy_out_d      = joy_out_q;
    valid_d        = 1'b0;
    prescale_clear = 1'b0;
`ifdef JAMMA_DB9_DEBOUNCE_EN
    prev_d         = prev_q;
`endif

    case (state_q)
      IDLE: begin
        // The gap counter parks at its terminal value while disabled, so a
        // re-enable starts the next frame straight away.
        if (gap_q == GAP_W'(SCAN_GAP - 1)) begin
          if (enable) begin
            gap_d          = '0;
            load_cnt_d     = '0;
            prescale_clear = 1'b1;
            state_d        = LOAD;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      LOAD: begin
        if (tick) begin
          if (load_cnt_q == LT_W'(LOAD_TICKS - 1)) begin
            state_d = SETTLE;
          end else begin
            load_cnt_d = load_cnt_q + LT_W'(1);
          end
        end
      end

      SETTLE: begin
        bit_idx_d = '0;
        phase_b_d = 1'b0;
        if (tick) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (!phase_b_q) begin
            // Tick A: capture the current bit, then rise the shift clock.
            // Shifting in at the LSB puts bit 'index' at TOTAL-1-index once
            // all TOTAL bits are in, so the first bit out ends up in the MSB.
            sr_d      = {sr_q[TOTAL-2:0], ~sync2_q};
            joy_clk_d = 1'b1;
            phase_b_d = 1'b1;
          end else begin
            // Tick B: fall the shift clock and move to the next bit.
            joy_clk_d = 1'b0;
            phase_b_d = 1'b0;
            if (bit_idx_q == IDX_W'(TOTAL - 1)) begin
              state_d = DONE;
            end else begin
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end
          end
        end
      end

      DONE: begin
        valid_d = 1'b1;
`ifdef JAMMA_DB9_DEBOUNCE_EN
        // A bit only follows the new capture when it matches the previous one.
        joy_out_d = (sr_q & agree) | (joy_out_q & ~agree);
        prev_d    = sr_q;
`else
        joy_out_d = sr_q;
`endif
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      load_cnt_q <= '0;
      bit_idx_q  <= '0;
      phase_b_q  <= 1'b0;
      sr_q       <= '0;
      joy_clk_q  <= 1'b0;
      joy_out_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      load_cnt_q <= load_cnt_d;
      bit_idx_q  <= bit_idx_d;
      phase_b_q  <= phase_b_d;
      sr_q       <= sr_d;
      joy_clk_q  <= joy_clk_d;
      joy_out_q  <= joy_out_d;
      valid_q    <= valid_d;
    end
  end

`ifdef JAMMA_DB9_DEBOUNCE_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`endif

  assign joy_clk    = joy_clk_q;
  assign joy_load_n = (state_q != LOAD);
  assign joy_select = 1'b1;
  assign joy_out    = joy_out_q;
  assign joy_valid  = valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_jamma_db9_scanner.sv
// Bench for jamma_db9_scanner: a behavioural 74HC165 chain feeds the DUT,
// a reference model pushes the expected button word at each load pulse and
// a monitor pops and compares on every joy_valid.
module tb_jamma_db9_scanner;

  localparam int NUM_CH     = 2;
  localparam int CH_BITS    = 12;
  localparam int CLK_DIV    = 8;
  localparam int LOAD_TICKS = 2;
  localparam int SCAN_GAP   = 1024;
  localparam int TOTAL      = NUM_CH * CH_BITS;
  localparam int FRAME_LEN  = (LOAD_TICKS + 1 + 2 * TOTAL) * CLK_DIV + 1;

  logic             clk_sys = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             joy_data;
  logic             joy_clk;
  logic             joy_load_n;
  logic             joy_select;
  logic [TOTAL-1:0] joy_out;
  logic             joy_valid;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  logic [TOTAL-1:0] exp_q[$];
  logic [TOTAL-1:0] pattern = '1;   // wire levels the chain loads (active-low)
  logic [TOTAL-1:0] chain;
  logic [TOTAL-1:0] model_out  = '0;
  logic [TOTAL-1:0] model_prev = '0;

  jamma_db9_scanner #(
    .NUM_CH     (NUM_CH),
    .CH_BITS    (CH_BITS),
    .CLK_DIV    (CLK_DIV),
    .LOAD_TICKS (LOAD_TICKS),
    .SCAN_GAP   (SCAN_GAP)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .enable     (enable),
    .joy_data   (joy_data),
    .joy_clk    (joy_clk),
    .joy_load_n (joy_load_n),
    .joy_select (joy_select),
    .joy_out    (joy_out),
    .joy_valid  (joy_valid),
    .busy       (busy)
  );

  // ---------------- clock / reset-relative cycle count ----------------
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- chain model ----------------
  always @(posedge joy_clk or negedge joy_load_n) begin
    if (!joy_load_n) chain <= pattern;
    else             chain <= {chain[TOTAL-2:0], 1'b1};
  end
  assign joy_data = chain[TOTAL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model: expected word per frame ----------------
  always @(negedge joy_load_n or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      model_out  = '0;
      model_prev = '0;
    end else begin
      logic [TOTAL-1:0] raw;
      raw = ~pattern;
`ifdef JAMMA_DB9_DEBOUNCE_EN
      for (int i = 0; i < TOTAL; i++)
        if (raw[i] == model_prev[i]) model_out[i] = raw[i];
      model_prev = raw;
`else
      model_out = raw;
`endif
      exp_q.push_back(model_out);
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_sys) begin
    if (rst_n && joy_valid) begin
      if (exp_q.size() == 0) begin
        check("valid_without_frame", 32'(joy_valid), 32'd0);
      end else begin
        logic [TOTAL-1:0] e;
        e = exp_q.pop_front();
        check("joy_out", 32'(joy_out), 32'(e));
      end
    end
  end

  // ---------------- frame waveform monitor ----------------
  int  load_len, rises, hi_len, lo_len, hi_bad, lo_bad;
  bit  tracking, seen_rise;
  logic prev_clk_s = 1'b0, prev_load_s = 1'b1;

  always @(negedge clk_sys) begin
    if (!rst_n) begin
      tracking = 0;
      prev_clk_s = 1'b0;
      prev_load_s = 1'b1;
    end else begin
      if (!joy_load_n) begin
        if (prev_load_s) begin
          load_len = 0; rises = 0; hi_bad = 0; lo_bad = 0;
          seen_rise = 0; tracking = 1;
        end
        load_len++;
      end
      if (joy_clk && !prev_clk_s) begin
        if (seen_rise && lo_len != CLK_DIV) lo_bad++;
        rises++;
        hi_len = 0;
        seen_rise = 1;
      end
      if (!joy_clk && prev_clk_s) begin
        if (hi_len != CLK_DIV) hi_bad++;
        lo_len = 0;
      end
      if (joy_clk) hi_len++;
      else         lo_len++;
      if (joy_valid && tracking) begin
        check("clk_rises_per_frame", 32'(rises), 32'(TOTAL));
        check("load_low_cycles", 32'(load_len), 32'(LOAD_TICKS * CLK_DIV));
        check("clk_high_phase_bad", 32'(hi_bad), 32'd0);
        check("clk_low_phase_bad", 32'(lo_bad), 32'd0);
        tracking = 0;
      end
      prev_clk_s  = joy_clk;
      prev_load_s = joy_load_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_load_fall(input int budget, output int at_cyc, output bit ok);
    logic last;
    last = joy_load_n;
    ok = 0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (last && !joy_load_n) begin
        ok = 1;
        at_cyc = cyc;
        break;
      end
      last = joy_load_n;
    end
  endtask

  task automatic wait_valid(input int budget, output int at_cyc, output bit ok);
    ok = 0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (joy_valid) begin
        ok = 1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_rises(input int n, input int budget, output bit ok);
    logic last;
    int   cnt;
    last = joy_clk;
    cnt = 0;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (joy_clk && !last) cnt++;
      last = joy_clk;
      if (cnt == n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_frames(input int n);
    int c;
    bit ok;
    for (int f = 0; f < n; f++) begin
      wait_load_fall(SCAN_GAP + FRAME_LEN + 16, c, ok);
      check("load_fall_seen", 32'(ok), 32'd1);
      wait_valid(FRAME_LEN + 16, c, ok);
      check("valid_seen", 32'(ok), 32'd1);
    end
  endtask

  task automatic set_random_pattern();
    logic [31:0] r;
    r = $urandom;
    pattern = r[TOTAL-1:0];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    bit ok;
    logic [TOTAL-1:0] held;

    rst_n   = 1'b0;
    enable  = 1'b1;
    pattern = '1;
    repeat (3) @(negedge clk_sys);

    check("rst_joy_clk", 32'(joy_clk), 32'd0);
    check("rst_joy_load_n", 32'(joy_load_n), 32'd1);
    check("rst_joy_select", 32'(joy_select), 32'd1);
    check("rst_joy_out", 32'(joy_out), 32'd0);
    check("rst_joy_valid", 32'(joy_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    rst_n = 1'b1;

    // First frame: timing from reset release, no buttons pressed.
    wait_load_fall(SCAN_GAP + 16, c, ok);
    check("first_load_seen", 32'(ok), 32'd1);
    check("first_load_cycle", 32'(c), 32'(SCAN_GAP));
    check("busy_in_frame", 32'(busy), 32'd1);
    wait_valid(FRAME_LEN + 16, c, ok);
    check("first_valid_seen", 32'(ok), 32'd1);
    check("first_valid_cycle", 32'(c), 32'(SCAN_GAP + FRAME_LEN));
    check("first_frame_out", 32'(joy_out), 32'd0);

    // Ordering and inversion: first bit out pressed plus last bit pressed.
    pattern = 24'h7FFFFE;
    run_frames(2);
    check("msb_lsb_pattern", 32'(joy_out), 32'h800001);

    // Randomised frames.
    for (int k = 0; k < 8; k++) begin
      set_random_pattern();
      run_frames($urandom_range(1, 2));
    end

    // Drop enable part-way through a frame.
    set_random_pattern();
    wait_load_fall(SCAN_GAP + FRAME_LEN + 16, c, ok);
    check("en_load_seen", 32'(ok), 32'd1);
    wait_rises(10, FRAME_LEN, ok);
    check("en_rises_seen", 32'(ok), 32'd1);
    enable = 1'b0;
    wait_valid(FRAME_LEN + 16, c, ok);
    check("en_frame_completes", 32'(ok), 32'd1);
    held = joy_out;
    set_random_pattern();
    wait_load_fall(3 * SCAN_GAP, c, ok);
    check("no_load_while_disabled", 32'(ok), 32'd0);
    check("out_held_while_disabled", 32'(joy_out), 32'(held));
    enable = 1'b1;
    wait_load_fall(SCAN_GAP + 2, c, ok);
    check("resume_after_enable", 32'(ok), 32'd1);
    wait_valid(FRAME_LEN + 16, c, ok);
    check("resume_valid", 32'(ok), 32'd1);

    // Asynchronous reset in the middle of a frame.
    set_random_pattern();
    wait_load_fall(SCAN_GAP + FRAME_LEN + 16, c, ok);
    check("rstmid_load_seen", 32'(ok), 32'd1);
    wait_rises(5, FRAME_LEN, ok);
    check("rstmid_rises_seen", 32'(ok), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_joy_clk", 32'(joy_clk), 32'd0);
    check("rstmid_joy_load_n", 32'(joy_load_n), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_joy_out", 32'(joy_out), 32'd0);
    check("rstmid_joy_valid", 32'(joy_valid), 32'd0);
    repeat (4) @(negedge clk_sys);
    rst_n = 1'b1;
    set_random_pattern();
    run_frames(2);

`ifdef JAMMA_DB9_DEBOUNCE_EN
    // Single-frame glitch on button bit 3 must not reach joy_out.
    pattern = '1;
    run_frames(2);
    pattern = 24'hFFFFF7;
    run_frames(1);
    check("deb_one_frame_press", 32'(joy_out[3]), 32'd0);
    pattern = '1;
    run_frames(1);
    check("deb_after_release", 32'(joy_out[3]), 32'd0);
    pattern = 24'hFFFFF7;
    run_frames(1);
    check("deb_first_of_two", 32'(joy_out[3]), 32'd0);
    run_frames(1);
    check("deb_second_of_two", 32'(joy_out[3]), 32'd1);
`endif

    repeat (4) @(negedge clk_sys);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
